remap_alu_csr: RTL and testbench

//  Bus-programmed ALU with a register window that is remapped at run time.
//  A MAP register at absolute address 0 picks which address window exposes
//  the operand, control, status and result registers.

---
 rtl/remap_alu_csr.sv | 170 +++++++++++++++++
 tb/tb_remap_alu_csr.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/remap_alu_csr.sv
// Bus-programmed ALU whose operand/control/status/result registers live in a
// window selected at run time by the MAP register at absolute address 0.
module remap_alu_csr #(
  parameter int unsigned DW         = 16,
  parameter int unsigned AW         = 16,
  parameter int unsigned OPW        = 8,
  parameter int unsigned N_MAPS     = 4,
  parameter int unsigned MAP_STRIDE = 8,
  parameter int unsigned MUL_LAT    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          bus_valid,
  input  logic          bus_op,
  input  logic [AW-1:0] bus_addr,
  input  logic [DW-1:0] bus_wr_data,
  output logic [DW-1:0] bus_rd_data,
  output logic          bus_rd_valid,
  output logic          done,
  output logic          irq
);

  localparam int unsigned MAPW = (N_MAPS > 1) ? $clog2(N_MAPS) : 1;
  localparam int unsigned CNTW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [MAPW-1:0] map_q;
  logic [DW-1:0]   opa_q;
  logic [DW-1:0]   opb_q;
  logic [2:0]      ctrl_op_q;
  logic            irq_en_q;
  logic            done_q;
  logic            err_q;
  logic [DW-1:0]   result_q;
  logic [OPW-1:0]  lat_a;
  logic [OPW-1:0]  lat_b;
  logic [2:0]      lat_op;

  logic [AW-1:0] base;
  logic [AW-1:0] offs;
  logic          sel_map, sel_opa, sel_opb, sel_ctrl, sel_status, sel_result;
  logic          wr, rd, busy;
  logic          start_req, op_valid, launch, err_set, complete;
  logic          done_nxt, err_nxt, irq_en_nxt;
  logic [DW-1:0] rd_mux;
  logic [DW-1:0] ctrl_rd;
  logic [DW-1:0] alu_res;
  logic [OPW:0]      sum;
  logic [2*OPW-1:0]  prod;

  // Address decode: MAP is fixed at 0, the rest follows the selected window
  always_comb begin
    base       = AW'(map_q) * AW'(MAP_STRIDE);
    offs       = bus_addr - base;
    sel_map    = (bus_addr == '0);
    sel_opa    = !sel_map && (bus_addr >= base) && (offs == AW'(1));
    sel_opb    = !sel_map && (bus_addr >= base) && (offs == AW'(2));
    sel_ctrl   = !sel_map && (bus_addr >= base) && (offs == AW'(3));
    sel_status = !sel_map && (bus_addr >= base) && (offs == AW'(4));
    sel_result = !sel_map && (bus_addr >= base) && (offs == AW'(5));
  end

  // Control strobes and next values of the sticky/status bits
  always_comb begin
    wr         = bus_valid && bus_op;
    rd         = bus_valid && !bus_op;
    busy       = (state == EXEC);
    start_req  = wr && sel_ctrl && bus_wr_data[15];
    op_valid   = (bus_wr_data[2:0] >= OP_ADD) && (bus_wr_data[2:0] <= OP_MUL);
    launch     = start_req && !busy && op_valid;
    err_set    = start_req && (busy || (bus_wr_data[2:0] > OP_MUL));
    complete   = busy && (cnt == '0);
    // Completion sets done even if the same cycle carries a W1C for it
    done_nxt   = complete || (done_q && !(wr && sel_status && bus_wr_data[1]));
    err_nxt    = err_set || (err_q && !(wr && sel_status && bus_wr_data[2]));
    irq_en_nxt = (wr && sel_ctrl) ? bus_wr_data[14] : irq_en_q;
  end

  // ALU on the operands latched at start
  always_comb begin
    sum     = {1'b0, lat_a} + {1'b0, lat_b};
    prod    = {{OPW{1'b0}}, lat_a} * {{OPW{1'b0}}, lat_b};
    alu_res = '0;
    case (lat_op)
      OP_ADD:  alu_res = DW'(sum);
      OP_AND:  alu_res = DW'(lat_a & lat_b);
      OP_XOR:  alu_res = DW'(lat_a ^ lat_b);
      OP_MUL:  alu_res = DW'(prod);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    ctrl_rd        = '0;
    ctrl_rd[14]    = irq_en_q;
    ctrl_rd[2:0]   = ctrl_op_q;
    rd_mux         = '0;
    if (sel_map)         rd_mux = DW'(map_q);
    else if (sel_opa)    rd_mux = opa_q;
    else if (sel_opb)    rd_mux = opb_q;
    else if (sel_ctrl)   rd_mux = ctrl_rd;
    else if (sel_status) rd_mux = DW'({err_q, done_q, busy});
    else if (sel_result) rd_mux = result_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      map_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      ctrl_op_q    <= '0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      result_q     <= '0;
      lat_a        <= '0;
      lat_b        <= '0;
      lat_op       <= '0;
      bus_rd_data  <= '0;
      bus_rd_valid <= 1'b0;
      done         <= 1'b0;
      irq          <= 1'b0;
    end else begin
      bus_rd_valid <= rd;
      if (rd) bus_rd_data <= rd_mux;

      if (wr && sel_map && (bus_wr_data < DW'(N_MAPS))) map_q <= MAPW'(bus_wr_data);
      if (wr && sel_opa) opa_q <= bus_wr_data;
      if (wr && sel_opb) opb_q <= bus_wr_data;
      if (wr && sel_ctrl) ctrl_op_q <= bus_wr_data[2:0];
      irq_en_q <= irq_en_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
      done     <= complete;
      irq      <= done_nxt && irq_en_nxt;

      case (state)
        IDLE: begin
          if (launch) begin
            lat_a  <= opa_q[OPW-1:0];
            lat_b  <= opb_q[OPW-1:0];
            lat_op <= bus_wr_data[2:0];
            cnt    <= (bus_wr_data[2:0] == OP_MUL) ? CNTW'(MUL_LAT - 1) : '0;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            result_q <= alu_res;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_remap_alu_csr.sv
// Directed scoreboard bench for remap_alu_csr: the driver queues expected read
// data and done cycles, a negedge monitor checks them as the DUT produces them.
module tb_remap_alu_csr;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bus_valid = 1'b0;
  logic        bus_op = 1'b0;
  logic [15:0] bus_addr = '0;
  logic [15:0] bus_wr_data = '0;
  logic [15:0] bus_rd_data;
  logic        bus_rd_valid;
  logic        done;
  logic        irq;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      done_q[$];

  remap_alu_csr #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .bus_valid(bus_valid), .bus_op(bus_op),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rd_valid(bus_rd_valid), .done(done), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every read response and every done pulse must match a queued expectation
  always @(negedge clk) begin
    if (bus_rd_valid) begin
      n_checks++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid with data 0x%04h, required no read", bus_rd_data);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        if (bus_rd_data !== e.data) begin
          n_fail++;
          $display("FAIL rd_addr_%0d: got 0x%04h, required 0x%04h", e.addr, bus_rd_data, e.data);
        end
      end
    end
    if (done) begin
      n_checks++;
      if (done_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
      end else begin
        int e;
        e = done_q.pop_front();
        if (cyc != e) begin
          n_fail++;
          $display("FAIL done_cycle: got cycle %0d, required cycle %0d", cyc, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, required 0x%04h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus_valid = 1'b1; bus_op = 1'b1; bus_addr = a; bus_wr_data = d;
    @(negedge clk);
    bus_valid = 1'b0; bus_op = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp);
    rd_exp_t e;
    e.addr = a; e.data = exp;
    rd_q.push_back(e);
    bus_valid = 1'b1; bus_op = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_valid = 1'b0;
  endtask

  // Start write; lat > 0 queues a done expected lat edges after the start edge
  task automatic start(input logic [15:0] a, input logic [15:0] d, input int lat);
    wr(a, d);
    if (lat > 0) done_q.push_back(cyc + lat);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50 && done_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL done_timeout: got %0d pending done, required 0", done_q.size());
      done_q.delete();
    end
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_done", 16'(done), 16'h0);
    check("rst_irq", 16'(irq), 16'h0);
    check("rst_rd_valid", 16'(bus_rd_valid), 16'h0);
    reset_n = 1'b1;
    idle(1);
    rd(16'd0, 16'h0000);
    rd(16'd4, 16'h0000);
    rd(16'd5, 16'h0000);

    // 1: add in map 0
    wr(16'd1, 16'h00FF);
    wr(16'd2, 16'h0001);
    start(16'd3, 16'h8001, 1);
    wait_done();
    rd(16'd5, 16'h0100);
    rd(16'd4, 16'h0002);
    rd(16'd3, 16'h0001);

    // 2: remap to window 2, unmapped reads, ignored MAP value
    wr(16'd0, 16'h0002);
    wr(16'd17, 16'h0003);
    rd(16'd17, 16'h0003);
    rd(16'd1, 16'h0000);
    wr(16'd0, 16'h0007);
    rd(16'd0, 16'h0002);
    rd(16'd20, 16'h0002);
    rd(16'd22, 16'h0000);
    wr(16'd0, 16'h0000);

    // 3: multiply latency, irq and W1C of done
    wr(16'd4, 16'h0002);
    wr(16'd1, 16'h00FF);
    wr(16'd2, 16'h00FF);
    start(16'd3, 16'hC004, MUL_LAT);
    wait_done();
    check("mul_irq_set", 16'(irq), 16'h1);
    rd(16'd5, 16'hFE01);
    wr(16'd4, 16'h0002);
    check("irq_cleared", 16'(irq), 16'h0);
    wr(16'd5, 16'h1234);
    rd(16'd5, 16'hFE01);

    // 4: start and OPA rewrite while busy
    start(16'd3, 16'hC004, MUL_LAT);
    wr(16'd3, 16'h8001);
    wr(16'd1, 16'h0000);
    wait_done();
    rd(16'd5, 16'hFE01);
    rd(16'd4, 16'h0006);
    wr(16'd4, 16'h0006);
    rd(16'd4, 16'h0000);

    // 5: W1C of done in the completion cycle, then an illegal op
    start(16'd3, 16'h8001, 1);
    wr(16'd4, 16'h0002);
    wait_done();
    rd(16'd4, 16'h0002);
    rd(16'd5, 16'h00FF);
    wr(16'd4, 16'h0002);
    wr(16'd3, 16'h8006);
    idle(4);
    rd(16'd4, 16'h0004);

    // 6: reset in the middle of a multiply in window 1
    wr(16'd0, 16'h0001);
    wr(16'd9, 16'h00FF);
    rd(16'd9, 16'h00FF);
    wr(16'd11, 16'h8004);
    reset_n = 1'b0;
    idle(1);
    check("mid_rst_done", 16'(done), 16'h0);
    check("mid_rst_rd_valid", 16'(bus_rd_valid), 16'h0);
    reset_n = 1'b1;
    idle(5);
    rd(16'd0, 16'h0000);
    rd(16'd4, 16'h0000);
    rd(16'd5, 16'h0000);
    rd(16'd1, 16'h0000);
    check("post_rst_irq", 16'(irq), 16'h0);

    // Drain and confirm nothing is left outstanding
    for (int i = 0; i < 20 && rd_q.size() != 0; i++) @(negedge clk);
    check("rd_queue_left", 16'(rd_q.size()), 16'h0);
    check("done_queue_left", 16'(done_q.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
